mmu_fifo_reader: RTL
====================

Name: mmu_fifo_reader

Overview:
- Read-side controller for the MMU input FIFOs: drains a commanded number of words from one first-word-fall-through FIFO and presents them to the systolic-array feeder as a valid/ready stream with a last marker.
- Sits between the FIFO read port (rden/empty/rdata) and the MMU row feeder.
- Provides a command/busy/done interface to the tile sequencer.

Parameters:
- DATA_WIDTH, 32, FIFO word width in bits.
- LEN_WIDTH, 8, width of the burst-length command; maximum burst is 2^LEN_WIDTH-1 words.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  command strobe; sampled only in IDLE.
- len_i  input  LEN_WIDTH  number of words to drain; sampled with start_i.
- busy_o  output  1  high in RUN and DRAIN states.
- done_o  output  1  one-cycle pulse when the burst completes.
- fifo_empty_i  input  1  FIFO empty flag.
- fifo_rdata_i  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty_i is low.
- fifo_rden_o  output  1  pop strobe; the FIFO advances its read pointer on the clk edge.
- out_valid_o  output  1  output word valid.
- out_ready_i  input  1  downstream accepts when high together with out_valid_o.
- out_data_o  output  DATA_WIDTH  output word, registered.
- out_last_o  output  1  high with the final word of the burst.

Behaviour:
- Reset values: state=IDLE, remaining count=0, out_valid_o=0, out_data_o=0, out_last_o=0, done_o=0, busy_o=0, fifo_rden_o=0.
- fifo_rden_o is combinational and equals pop.
- pop = (state==RUN) && remaining!=0 && !fifo_empty_i && (!out_valid_o || out_ready_i).
- fifo_rden_o is never high while fifo_empty_i is high or when remaining is 0.
- IDLE:
  - start_i with len_i!=0: load remaining=len_i and go to RUN.
  - start_i with len_i==0: stay in IDLE and pulse done_o on the next cycle; no data is issued.
- RUN:
  - Each pop registers fifo_rdata_i into out_data_o, sets out_valid_o, and decrements remaining.
  - out_last_o is set on the pop where remaining==1.
  - After that pop, go to DRAIN.
- DRAIN: wait for the handshake out_valid_o && out_ready_i with out_last_o=1, then clear out_valid_o and out_last_o, pulse done_o for one cycle, and return to IDLE.
- Handshake rules:
  - out_data_o, out_last_o and out_valid_o hold stable while out_valid_o && !out_ready_i.
  - A handshake and a pop in the same cycle reload the register, so out_valid_o stays high. Sustained throughput is 1 word/clk.
  - A handshake without a pop clears out_valid_o.
- Latency: start_i at edge N puts the block in RUN at N+1. If the FIFO is non-empty, the pop occurs in that cycle and out_valid_o is high after edge N+2.
- FIFO empty in RUN: stall with no pop. out_valid_o drops after the current word is accepted. busy_o stays high.
- start_i while busy: ignored, with no effect on count or data.
- Reset mid-burst: all state returns to reset values immediately, and the word held in out_data_o is lost. FIFO contents already popped are not restored. The sequencer reissues the command.
- done_o and start_i in the same cycle: the block is in IDLE, so start_i is accepted.

Optional Feature:
- Macro: MMU_FIFO_RD_STALL_CNT_EN.
- When defined:
  - Adds output port stall_cnt_o, 16 bits.
  - Counts cycles in RUN with remaining!=0 and fifo_empty_i high.
  - Cleared on reset and on an accepted start_i.
  - Saturates at 16'hFFFF.
  - Holds its value after done_o.
- When undefined: no port and no counter logic. All other behaviour is identical.

Decomposition:
- Shared package mmu_pkg:
  - state enum typedef for IDLE, RUN, DRAIN (2 bits).
  - default DATA_WIDTH and LEN_WIDTH constants.
  - stall-counter width constant.
- Sub-module mmu_out_stage: the single-entry registered valid/ready output stage (load, hold, clear logic).
- The FSM and counter stay in the top module.

Test Plan:
- Basic burst: FIFO preloaded with 0x11,0x22,0x33, out_ready_i=1, start_i len_i=3 -> three consecutive valid words 0x11,0x22,0x33; out_last_o only on 0x33; done_o pulse one cycle after the last handshake; exactly 3 fifo_rden_o pulses.
- Backpressure: len_i=4, out_ready_i toggling 1,0,0,1,... -> data held stable while not ready; no pop while output is full and not ready; order preserved; 4 pops total.
- Underflow stall: FIFO holds 1 word, len_i=3, remaining words written 5 cycles later -> fifo_rden_o never high while empty; busy_o held; completes with 3 words. With the macro defined, stall_cnt_o equals the number of empty cycles in RUN.
- Zero length and start while busy: len_i=0 -> done_o pulse, no rden, no valid. start_i during RUN -> ignored; count unchanged.
- Reset mid-burst: assert rst_n low after 2 of 5 words -> all outputs 0 asynchronously. A new start with len_i=2 then drains the next 2 FIFO words correctly.
- Max length: len_i=255 with continuous data and ready -> 255 words at 1/clk, single out_last_o, single done_o.

Source files
------------

// File: rtl/mmu_pkg.sv
// Shared types and constants for the MMU input-FIFO read controller.
// The stall counter (MMU_FIFO_RD_STALL_CNT_EN) uses the width and saturating helper below.
package mmu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } mmu_rd_state_t;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_LEN_WIDTH   = 8;
  localparam int STALL_CNT_WIDTH = 16;

  localparam logic [STALL_CNT_WIDTH-1:0] STALL_CNT_MAX = 16'hFFFF;

  function automatic logic [STALL_CNT_WIDTH-1:0] stall_sat_inc(
    input logic [STALL_CNT_WIDTH-1:0] value
  );
    logic [STALL_CNT_WIDTH-1:0] result_s;
    if (value == STALL_CNT_MAX) begin
      result_s = value;
    end else begin
      result_s = value + 16'd1;
    end
    return result_s;
  endfunction

endpackage

// File: rtl/mmu_out_stage.sv
// Single-entry registered valid/ready output stage: a load wins over a drain so a
// same-cycle handshake and refill keeps valid high for 1 word/clk throughput.
module mmu_out_stage
  import mmu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_last,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  last
);

  logic                  valid_r;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  last_r;

  // Output register: load on pop, clear on an accepted word, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_r <= 1'b0;
      data_r  <= {DATA_WIDTH{1'b0}};
      last_r  <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      data_r  <= load_data;
      last_r  <= load_last;
    end else if (valid_r && ready) begin
      valid_r <= 1'b0;
      last_r  <= 1'b0;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;
  assign last  = last_r;

endmodule

// File: rtl/mmu_fifo_reader.sv
// Drains a commanded number of words from a FWFT FIFO into a valid/ready stream with last.
// Optional stall-cycle counter port stall_cnt_o when MMU_FIFO_RD_STALL_CNT_EN is defined.
module mmu_fifo_reader
  import mmu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rden_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_last_o
`ifdef MMU_FIFO_RD_STALL_CNT_EN
  ,
  output logic [STALL_CNT_WIDTH-1:0] stall_cnt_o
`endif
);

  localparam logic [LEN_WIDTH-1:0] LEN_ZERO = LEN_WIDTH'(0);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  mmu_rd_state_t        state_r;
  mmu_rd_state_t        state_s;
  logic [LEN_WIDTH-1:0] remaining_r;
  logic [LEN_WIDTH-1:0] remaining_s;
  logic                 busy_r;
  logic                 done_r;
  logic                 done_s;
  logic                 pop_s;
  logic                 hs_s;
  logic                 last_pop_s;
  logic                 out_valid_s;
  logic                 out_last_s;

  // Pop only when a word is owed, one is available, and the output slot frees this cycle.
  always_comb begin
    pop_s      = 1'b0;
    hs_s       = out_valid_s && out_ready_i;
    last_pop_s = (remaining_r == LEN_ONE);
    if ((state_r == ST_RUN) && (remaining_r != LEN_ZERO) && !fifo_empty_i &&
        (!out_valid_s || out_ready_i)) begin
      pop_s = 1'b1;
    end else begin
      pop_s = 1'b0;
    end
  end

  // Next-state and done logic.
  always_comb begin
    state_s     = state_r;
    remaining_s = remaining_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != LEN_ZERO) begin
            state_s     = ST_RUN;
            remaining_s = len_i;
          end else begin
            done_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (pop_s) begin
          remaining_s = remaining_r - LEN_ONE;
          if (last_pop_s) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          remaining_s = remaining_r;
        end
      end
      ST_DRAIN: begin
        if (hs_s && out_last_s) begin
          state_s = ST_IDLE;
          done_s  = 1'b1;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        remaining_s = LEN_ZERO;
      end
    endcase
  end

  // FSM, burst counter and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      remaining_r <= LEN_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      remaining_r <= remaining_s;
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= done_s;
    end
  end

  mmu_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (pop_s),
    .load_data(fifo_rdata_i),
    .load_last(last_pop_s),
    .ready    (out_ready_i),
    .valid    (out_valid_s),
    .data     (out_data_o),
    .last     (out_last_s)
  );

`ifdef MMU_FIFO_RD_STALL_CNT_EN
  logic [STALL_CNT_WIDTH-1:0] stall_cnt_r;

  // Saturating count of RUN cycles starved by an empty FIFO; cleared by an accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= {STALL_CNT_WIDTH{1'b0}};
    end else if ((state_r == ST_IDLE) && start_i) begin
      stall_cnt_r <= {STALL_CNT_WIDTH{1'b0}};
    end else if ((state_r == ST_RUN) && (remaining_r != LEN_ZERO) && fifo_empty_i) begin
      stall_cnt_r <= stall_sat_inc(stall_cnt_r);
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

  assign fifo_rden_o = pop_s;
  assign out_valid_o = out_valid_s;
  assign out_last_o  = out_last_s;
  assign busy_o      = busy_r;
  assign done_o      = done_r;

endmodule
